// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-addressable data memory.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef logic [0:0] dmem_state_t;
  localparam dmem_state_t ST_CLEAR = 1'b0;
  localparam dmem_state_t ST_IDLE  = 1'b1;

  // Force address bits below the access size to zero; size 2'b11 behaves as word.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return off;
      SIZE_HALF: return {off[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << off;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_extract.sv
// Selects the addressed byte/halfword lane of a word and sign- or zero-extends it.
module byte_lane_extract import dmem_pkg::*; (
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {offset_i, 3'b000};

  always_comb begin
    result_o = word_i;
    case (size_i)
      SIZE_BYTE: result_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:   result_o = word_i;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// RV32 data memory: byte/half/word load-store, registered response, post-reset clear.
// Optional misalignment faulting is enabled by defining DMEM_MISALIGN_CHECK_EN.
module byte_data_memory import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_write_enable,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [ADDR_WIDTH-1:0] in_address,
  input  logic [31:0]           in_write_data,
  output logic                  out_ready,
  output logic                  out_valid,
  output logic [31:0]           out_data,
  output logic                  out_misaligned
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH_WORDS - 1);

  logic [31:0]     mem_q [DEPTH_WORDS];
  dmem_state_t     state_q, state_d;
  logic [IdxW-1:0] clr_cnt_q, clr_cnt_d;
  logic            valid_q, valid_d;
  logic [31:0]     data_q, data_d;
  logic            mis_q, mis_d;

  logic            accept;
  logic            misaligned;
  logic [1:0]      offset;
  logic [IdxW-1:0] idx;
  logic [3:0]      lane_en;
  logic [31:0]     wr_data;
  logic [31:0]     load_data;

  // High address bits wrap onto the array.
  assign idx = in_address[IdxW+1:2];

  generate
    if (ADDR_WIDTH > IdxW + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^in_address[ADDR_WIDTH-1:IdxW+2];
    end
  endgenerate

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = is_misaligned(in_size, in_address[1:0]);
  assign offset     = in_address[1:0];
`else
  assign misaligned = 1'b0;
  assign offset     = align_offset(in_size, in_address[1:0]);
`endif

  assign out_ready = (state_q == ST_IDLE);
  assign accept    = in_valid && out_ready;
  assign lane_en   = lane_enable(in_size, offset);

  always_comb begin
    wr_data = in_write_data;
    case (in_size)
      SIZE_BYTE: wr_data = {4{in_write_data[7:0]}};
      SIZE_HALF: wr_data = {2{in_write_data[15:0]}};
      default:   wr_data = in_write_data;
    endcase
  end

  byte_lane_extract u_extract (
    .word_i     (mem_q[idx]),
    .offset_i   (offset),
    .size_i     (in_size),
    .unsigned_i (in_unsigned),
    .result_o   (load_data)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LastIdx) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    valid_d = accept;
    mis_d   = accept && misaligned;
    data_d  = '0;
    if (accept && !in_write_enable && !misaligned) begin
      data_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      mis_q     <= mis_d;
    end
  end

  // Storage is deliberately unreset; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (accept && in_write_enable && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) begin
          mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_misaligned = mis_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Randomized self-checking bench for byte_data_memory against a byte-array model.
module tb_byte_data_memory;

  localparam int unsigned Depth = 32;
  localparam int unsigned Bytes = 4 * Depth;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_write_enable;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_address;
  logic [31:0] in_write_data;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_misaligned;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [7:0]  model_mem [Bytes];
  logic [31:0] got;

  byte_data_memory #(
    .DEPTH_WORDS (Depth),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_write_enable (in_write_enable),
    .in_size         (in_size),
    .in_unsigned     (in_unsigned),
    .in_address      (in_address),
    .in_write_data   (in_write_data),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_misaligned  (out_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned access_bytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    return (a % access_bytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned model_base(input logic [1:0] sz, input logic [31:0] a);
    int unsigned wrapped;
    wrapped = a % Bytes;
    return wrapped - (wrapped % access_bytes(sz));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
    int unsigned n, base;
    logic [31:0] val;
    n    = access_bytes(sz);
    base = model_base(sz, a);
    val  = 0;
    for (int k = 0; k < int'(n); k++) val = val + (32'(model_mem[base + k]) << (8 * k));
    if (n < 4 && !uns && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
    return val;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned base;
    base = model_base(sz, a);
    for (int k = 0; k < int'(access_bytes(sz)); k++) model_mem[base + k] = wd[8*k +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(Bytes); i++) model_mem[i] = 8'h00;
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] exp_data;
    logic        exp_mis;
    check("ready_before_req", 32'(out_ready), 32'd1);
    exp_mis  = model_mis(sz, addr);
    exp_data = (we || exp_mis) ? 32'd0 : model_load(sz, uns, addr);
    if (we && !exp_mis) model_store(sz, addr, wd);
    in_valid        = 1'b1;
    in_write_enable = we;
    in_size         = sz;
    in_unsigned     = uns;
    in_address      = addr;
    in_write_data   = wd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("resp_valid", 32'(out_valid), 32'd1);
    check("resp_data", out_data, exp_data);
    check("resp_misaligned", 32'(out_misaligned), 32'(exp_mis));
    rd = out_data;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
    check("idle_no_valid", 32'(out_valid), 32'd0);
  endtask

  // Release reset at a negedge, keep a store pending during clear, count edges to ready.
  task automatic release_and_wait_ready();
    int unsigned cnt;
    model_clear();
    reset           = 1'b1;
    in_valid        = 1'b1;
    in_write_enable = 1'b1;
    in_size         = 2'd2;
    in_address      = 32'h0;
    in_write_data   = 32'hFFFF_FFFF;
    check("ready_low_after_release", 32'(out_ready), 32'd0);
    cnt = 0;
    while (!out_ready && cnt < 4 * Depth) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      check("clear_ignores_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    check("ready_latency", cnt, Depth);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset           = 1'b0;
    in_valid        = 1'b0;
    in_write_enable = 1'b0;
    in_size         = 2'd0;
    in_unsigned     = 1'b0;
    in_address      = '0;
    in_write_data   = '0;
    model_clear();

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(out_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_misaligned", 32'(out_misaligned), 32'd0);
    release_and_wait_ready();

    for (int i = 0; i < 4; i++) begin
      req(1'b0, 2'd2, 1'b0, 32'($urandom_range(0, Depth - 1)) << 2, 32'd0, got);
      check("cleared_zero", got, 32'd0);
    end

    req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_80FF, got);
    req(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, got);
    check("lb_sign", got, 32'hFFFF_FFFF);
    req(1'b0, 2'd0, 1'b1, 32'h10, 32'd0, got);
    check("lbu_zero", got, 32'h0000_00FF);
    req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, got);
    check("lh_sign", got, 32'hFFFF_8000);
    req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, got);
    check("lhu_zero", got, 32'h0000_8000);

    req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, got);
    req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB, got);
    req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, got);
    check("sb_merge", got, 32'h1122_AB44);

    req(1'b1, 2'd2, 1'b0, 32'h0, 32'd10, got);
    req(1'b0, 2'd2, 1'b0, 32'h0, 32'd0, got);
    check("b2b_load0", got, 32'd10);
    req(1'b1, 2'd2, 1'b0, 32'h4, 32'd20, got);
    req(1'b0, 2'd2, 1'b0, 32'h4, 32'd0, got);
    check("b2b_load4", got, 32'd20);
    idle_cycle();

    req(1'b1, 2'd2, 1'b0, 32'(4 * Depth + 8), 32'h55, got);
    req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, got);
    check("addr_wrap", got, 32'h55);

    req(1'b1, 2'd2, 1'b0, 32'h30, 32'h1234_5678, got);
    req(1'b1, 2'd1, 1'b0, 32'h31, 32'h0000_BEEF, got);
    req(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, got);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("sh_misaligned_kept", got, 32'h1234_5678);
`else
    check("sh_aligned_down", got, 32'h1234_BEEF);
`endif

    for (int i = 0; i < 400; i++) begin
      req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 4 * Bytes - 1)), $urandom, got);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    // Reset while a response is on the outputs.
    req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, got);
    in_valid        = 1'b1;
    in_write_enable = 1'b0;
    in_size         = 2'd2;
    in_address      = 32'h40;
    @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("midreq_valid", 32'(out_valid), 32'd0);
    check("midreq_data", out_data, 32'd0);
    check("midreq_ready", 32'(out_ready), 32'd0);
    check("midreq_misaligned", 32'(out_misaligned), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    release_and_wait_ready();
    req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, got);
    check("post_reset_cleared", got, 32'd0);

    // Reset in the middle of clearing restarts the sweep.
    req(1'b1, 2'd2, 1'b0, 32'h7C, 32'hCAFE_F00D, got);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    release_and_wait_ready();
    req(1'b0, 2'd2, 1'b0, 32'h7C, 32'd0, got);
    check("midclear_cleared", got, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
